// File: rtl/fast_command_encoder_if.sv
// Fast command encoder bus: trigger/BCR controls, queued-command handshake and symbol/counter outputs.
// master drives requests and commands; slave is the encoder.
interface fast_command_encoder_if;
  logic        autoBCREn;
  logic        l1aReq;
  logic        cmdValid;
  logic [3:0]  cmdIndex;
  logic        cmdReady;
  logic [7:0]  fcSymbol;
  logic [3:0]  fcIndex;
  logic [11:0] bcid;
  logic [15:0] l1aCount;
  logic [7:0]  invalidCount;

  modport master (
    output autoBCREn, l1aReq, cmdValid, cmdIndex,
    input  cmdReady, fcSymbol, fcIndex, bcid, l1aCount, invalidCount
  );

  modport slave (
    input  autoBCREn, l1aReq, cmdValid, cmdIndex,
    output cmdReady, fcSymbol, fcIndex, bcid, l1aCount, invalidCount
  );
endinterface

// File: rtl/fast_command_encoder.sv
// Builds one fast command symbol per clk40 frame: L1A/auto-BCR take priority over a small command FIFO, idle fills gaps.
// Latency 1 frame from inputs to fcSymbol; cmdReady drops while the FIFO is full or reset is asserted.
module fast_command_encoder #(
  parameter int ORBIT_LEN  = 3564,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk40,
  input  logic                  reset,
  fast_command_encoder_if.slave fc
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [11:0] BCID_LAST = 12'(ORBIT_LEN - 1);

  localparam logic [3:0] IDX_IDLE    = 4'd0;
  localparam logic [3:0] IDX_BCR     = 4'd2;
  localparam logic [3:0] IDX_L1A     = 4'd6;
  localparam logic [3:0] IDX_L1A_BCR = 4'd7;

  logic [3:0]  mem_q [FIFO_DEPTH];
  logic [3:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]  fc_symbol_q, fc_symbol_d;
  logic [3:0]  fc_index_q, fc_index_d;
  logic [11:0] bcid_q, bcid_d;
  logic [15:0] l1a_count_q, l1a_count_d;
  logic [7:0]  invalid_count_q, invalid_count_d;

  logic       auto_bcr, full, empty, cmd_ready, accept, push, pop;
  logic [3:0] sel;

  function automatic logic [7:0] code_of(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h33;
      4'd2:    return 8'h5A;
      4'd3:    return 8'h55;
      4'd4:    return 8'h66;
      4'd5:    return 8'h69;
      4'd6:    return 8'h96;
      4'd7:    return 8'h99;
      4'd8:    return 8'hA5;
      4'd9:    return 8'hAA;
      default: return 8'hF0;
    endcase
  endfunction

  always_comb begin
    auto_bcr  = fc.autoBCREn && (bcid_q == BCID_LAST);
    full      = (count_q == (PW+1)'(FIFO_DEPTH));
    empty     = (count_q == '0);
    cmd_ready = !reset && !full;
    accept    = fc.cmdValid && cmd_ready;
    push      = accept && (fc.cmdIndex < 4'd10);
    pop       = 1'b0;

    // Trigger and orbit markers pre-empt the queue; the head waits until a free frame.
    if (auto_bcr && fc.l1aReq) begin
      sel = IDX_L1A_BCR;
    end else if (auto_bcr) begin
      sel = IDX_BCR;
    end else if (fc.l1aReq) begin
      sel = IDX_L1A;
    end else if (!empty) begin
      sel = mem_q[rd_ptr_q];
      pop = 1'b1;
    end else begin
      sel = IDX_IDLE;
    end

    fc_index_d  = sel;
    fc_symbol_d = code_of(sel);

    if (sel == IDX_BCR || sel == IDX_L1A_BCR || bcid_q == BCID_LAST) begin
      bcid_d = '0;
    end else begin
      bcid_d = bcid_q + 12'd1;
    end

    l1a_count_d = l1a_count_q;
    if ((sel == IDX_L1A || sel == IDX_L1A_BCR) && l1a_count_q != 16'hFFFF) begin
      l1a_count_d = l1a_count_q + 16'd1;
    end

    invalid_count_d = invalid_count_q;
    if (accept && !push && invalid_count_q != 8'hFF) begin
      invalid_count_d = invalid_count_q + 8'd1;
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = fc.cmdIndex;
    end
    wr_ptr_d = push ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop  ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      fc_symbol_q     <= 8'hF0;
      fc_index_q      <= IDX_IDLE;
      bcid_q          <= '0;
      l1a_count_q     <= '0;
      invalid_count_q <= '0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      fc_symbol_q     <= fc_symbol_d;
      fc_index_q      <= fc_index_d;
      bcid_q          <= bcid_d;
      l1a_count_q     <= l1a_count_d;
      invalid_count_q <= invalid_count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk40) begin
    mem_q <= mem_d;
  end

  assign fc.cmdReady     = cmd_ready;
  assign fc.fcSymbol     = fc_symbol_q;
  assign fc.fcIndex      = fc_index_q;
  assign fc.bcid         = bcid_q;
  assign fc.l1aCount     = l1a_count_q;
  assign fc.invalidCount = invalid_count_q;
endmodule
